fft_sequencer: RTL and testbench
================================

# fft_sequencer

Control sequencer for the in-place radix-2 DIT FFT datapath. On `start` it walks all log2(N) stages of an N-point transform held in a dual-port sample memory. Each cycle it issues one butterfly's read addresses (sample pair plus twiddle index) and, BF_LAT cycles later, the matching write-back addresses. It inserts a drain gap at every stage boundary so no stage reads data the previous stage has not yet written. It sits between the top-level FFT control and the address/enable pins of the sample memory, twiddle ROM and butterfly pipeline.

## Interface
Parameters:
- `N`, default 8: transform size; power of two, 4 ≤ N ≤ 1024. L = log2(N).
- `BF_LAT`, default 2: cycles from read-address issue to write-back data valid at the memory; 1 ≤ BF_LAT ≤ 8.

Ports:
- `clk` input 1: the only clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: start request; sampled only in IDLE.
- `abort` input 1: synchronous abort; highest priority after reset.
- `busy` output 1: high from the cycle after start is accepted until done.
- `done` output 1: one-cycle pulse after the final write.
- `rd_en` output 1: read strobe for the sample pair and twiddle.
- `rd_addr_a` output L: address of the butterfly top input.
- `rd_addr_b` output L: address of the butterfly bottom input.
- `tw_addr` output L-1: twiddle ROM index.
- `rd_stage` output L: stage of the current read.
- `wr_en` output 1: write strobe for both results.
- `wr_addr_a` output L: write address for the top output.
- `wr_addr_b` output L: write address for the bottom output.
- `wr_stage` output L: stage of the current write.

## Operation
- States:
  - IDLE: default state.
  - RUN: one butterfly per cycle, k = 0..N/2-1.
  - DRAIN: BF_LAT cycles.
  - DONE: 1 cycle.
- Transitions:
  - IDLE→RUN when `start`=1, with s=0, k=0.
  - RUN→DRAIN after k = N/2-1.
  - DRAIN→RUN after BF_LAT cycles if s < L-1, with s+1 and k=0.
  - DRAIN→DONE if s = L-1.
  - DONE→IDLE unconditionally.
- Address generation for stage s and index k:
  - half = 1<<s; pos = k & (half-1); grp = k>>s.
  - rd_addr_a = (grp<<(s+1)) | pos; rd_addr_b = rd_addr_a + half.
  - tw_addr = pos << (L-1-s).
  - All arithmetic is unsigned and truncated to port width.
- Input is in bit-reversed order in memory; reordering is the loader's job, not this block's.
- Write side: {rd_en, rd_addr_a, rd_addr_b, rd_stage} passes through a BF_LAT-deep register pipeline and emerges as {wr_en, wr_addr_a, wr_addr_b, wr_stage}.
- `rd_en` is high only in RUN. Address outputs are held at 0 whenever `rd_en`=0.
- Write address outputs are held at 0 whenever `wr_en`=0.
- `start` while not in IDLE is ignored. `start` held high in the DONE cycle does not restart; it is sampled next in IDLE.
- `abort`=1 in any state:
  - next cycle is IDLE;
  - all pipeline valid bits cleared, so no further `wr_en`;
  - `busy`=0; `done` is not pulsed.
- Reset (`rst_n`=0, any time, including mid-transform) has the same effect as `abort`, applied asynchronously.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `rd_en`, `wr_en` = 0;
  - all address and stage outputs = 0;
  - pipeline cleared.
- Cycle 0 is the cycle in which `start` is sampled high in IDLE. Let P = N/2 + BF_LAT.
- `busy`=1 from cycle 1 through cycle L·P inclusive.
- Stage s:
  - reads in cycles s·P+1 .. s·P+N/2;
  - writes in cycles s·P+1+BF_LAT .. (s+1)·P.
- The last write of stage s lands one cycle before the first read of stage s+1. The memory's read-during-write behaviour is therefore irrelevant.
- `done`=1 in cycle L·P+1 only, with `busy`=0 in that cycle.
- Total latency from start to done is L·P+1 cycles.
- Back-to-back: earliest accepted restart is cycle L·P+2.
- Outputs are registered; no combinational path from `start`/`abort` to any output.

## Test plan
- Reset then idle: hold `rst_n`=0 then release, no start → all outputs 0 for 20 cycles.
- Full run, N=8, BF_LAT=2: start at cycle 0 → read sequence, with (rd_addr_a, rd_addr_b / tw_addr):
  - stage 0 (tw 0 throughout): (0,1) (2,3) (4,5) (6,7);
  - stage 1 (tw 0,2,0,2): (0,2) (1,3) (4,6) (5,7);
  - stage 2 (tw 0,1,2,3): (0,4) (1,5) (2,6) (3,7);
  - writes repeat each pair 2 cycles later;
  - rd_en gaps are cycles 5–6 and 11–12;
  - last write at cycle 18; `done` at cycle 19; busy high cycles 1–18.
- Start while busy: pulse `start` at cycles 3 and 10 → trace identical to the full-run case.
- Abort mid-stage: `abort` at cycle 8 (stage 1) → IDLE at cycle 9; no `wr_en` from cycle 9 on; no `done`; a new start at cycle 12 gives a fresh full trace.
- Async reset mid-run: drop `rst_n` between edges at cycle 14 → outputs go to 0 immediately, before the next edge; after release, idle until start.
- Parameter sweep: N=16 with BF_LAT=1, and N=1024 with BF_LAT=8 → every address appears exactly once per stage on rd_addr_a ∪ rd_addr_b; `done` at cycle L·P+1 (N=16, BF_LAT=1: cycle 37).

Source files
------------

// File: rtl/fft_sequencer.sv
// Address/enable sequencer for an in-place radix-2 DIT FFT over a dual-port sample memory.
// Issues one butterfly read per cycle and replays it as a write-back BF_LAT cycles later.
module fft_sequencer #(
    parameter int unsigned N      = 8,
    parameter int unsigned BF_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [$clog2(N)-1:0]   rd_addr_a,
    output logic [$clog2(N)-1:0]   rd_addr_b,
    output logic [$clog2(N)-2:0]   tw_addr,
    output logic [$clog2(N)-1:0]   rd_stage,
    output logic                   wr_en,
    output logic [$clog2(N)-1:0]   wr_addr_a,
    output logic [$clog2(N)-1:0]   wr_addr_b,
    output logic [$clog2(N)-1:0]   wr_stage
);

    localparam int unsigned L  = $clog2(N);
    localparam int unsigned KW = L - 1;
    localparam int unsigned TW = L - 1;
    localparam int unsigned CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam int unsigned PW = 1 + 3 * L;

    localparam logic [KW-1:0] K_LAST   = KW'(N / 2 - 1);
    localparam logic [L-1:0]  STG_LAST = L'(L - 1);
    localparam logic [CW-1:0] D_LAST   = CW'(BF_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [L-1:0]  stg_q, stg_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic [L-1:0]  half_c, pos_c, grp_c, kx_c, addr_a_c, addr_b_c;
    logic [TW-1:0] tw_c;
    logic          rd_en_d;

    logic [PW-1:0] pipe_q [BF_LAT];

    // Next-state and loop counters; abort overrides everything.
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        if (abort) begin
            state_d = S_IDLE;
            stg_d   = '0;
            k_d     = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        stg_d   = '0;
                        k_d     = '0;
                    end
                end
                S_RUN: begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == D_LAST) begin
                        dcnt_d = '0;
                        if (stg_q == STG_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                            stg_d   = stg_q + L'(1);
                            k_d     = '0;
                        end
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Butterfly addresses for the upcoming cycle's stage/index.
    always_comb begin
        kx_c     = L'(k_d);
        half_c   = L'(1) << stg_d;
        pos_c    = kx_c & (half_c - L'(1));
        grp_c    = kx_c >> stg_d;
        addr_a_c = (grp_c << (stg_d + L'(1))) | pos_c;
        addr_b_c = addr_a_c + half_c;
        tw_c     = TW'(pos_c << (L'(L - 1) - stg_d));
        rd_en_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stg_q     <= '0;
            k_q       <= '0;
            dcnt_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            rd_stage  <= '0;
        end else begin
            state_q   <= state_d;
            stg_q     <= stg_d;
            k_q       <= k_d;
            dcnt_q    <= dcnt_d;
            busy      <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done      <= (state_d == S_DONE);
            rd_en     <= rd_en_d;
            rd_addr_a <= rd_en_d ? addr_a_c : '0;
            rd_addr_b <= rd_en_d ? addr_b_c : '0;
            tw_addr   <= rd_en_d ? tw_c : '0;
            rd_stage  <= rd_en_d ? stg_d : '0;
        end
    end

    // Write-back delay line; flushed on abort so no stale write escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BF_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= abort ? '0 : {rd_en, rd_addr_a, rd_addr_b, rd_stage};
            for (int unsigned i = 1; i < BF_LAT; i++) pipe_q[i] <= abort ? '0 : pipe_q[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b, wr_stage} = pipe_q[BF_LAT-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: cycle-exact N=8 trace scoreboard plus coverage sweeps at N=16 and N=1024.
module tb_fft_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start16 = 1'b0;
    logic start1k = 1'b0;
    logic abort_sw = 1'b0;

    always #5 clk = ~clk;

    // N=8, BF_LAT=2 instance
    logic       busy8, done8, rd_en8, wr_en8;
    logic [2:0] rda8, rdb8, rds8, wra8, wrb8, wrs8;
    logic [1:0] tw8;
    logic [23:0] obs8;
    assign obs8 = {busy8, done8, rd_en8, rda8, rdb8, tw8, rds8, wr_en8, wra8, wrb8, wrs8};

    fft_sequencer #(.N(8), .BF_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy8), .done(done8), .rd_en(rd_en8),
        .rd_addr_a(rda8), .rd_addr_b(rdb8), .tw_addr(tw8), .rd_stage(rds8),
        .wr_en(wr_en8), .wr_addr_a(wra8), .wr_addr_b(wrb8), .wr_stage(wrs8)
    );

    // N=16, BF_LAT=1 instance
    logic       busy16, done16, rd_en16, wr_en16;
    logic [3:0] rda16, rdb16, rds16, wra16, wrb16, wrs16;
    logic [2:0] tw16;

    fft_sequencer #(.N(16), .BF_LAT(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort_sw),
        .busy(busy16), .done(done16), .rd_en(rd_en16),
        .rd_addr_a(rda16), .rd_addr_b(rdb16), .tw_addr(tw16), .rd_stage(rds16),
        .wr_en(wr_en16), .wr_addr_a(wra16), .wr_addr_b(wrb16), .wr_stage(wrs16)
    );

    // N=1024, BF_LAT=8 instance
    logic       busy1k, done1k, rd_en1k, wr_en1k;
    logic [9:0] rda1k, rdb1k, rds1k, wra1k, wrb1k, wrs1k;
    logic [8:0] tw1k;

    fft_sequencer #(.N(1024), .BF_LAT(8)) dut1k (
        .clk(clk), .rst_n(rst_n), .start(start1k), .abort(abort_sw),
        .busy(busy1k), .done(done1k), .rd_en(rd_en1k),
        .rd_addr_a(rda1k), .rd_addr_b(rdb1k), .tw_addr(tw1k), .rd_stage(rds1k),
        .wr_en(wr_en1k), .wr_addr_a(wra1k), .wr_addr_b(wrb1k), .wr_stage(wrs1k)
    );

    // Reference read order for N=8 (stage-major, four butterflies per stage)
    int unsigned ta  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int unsigned tb_ [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int unsigned ttw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    localparam int TP  = 6;   // N/2 + BF_LAT
    localparam int TLP = 18;  // L * P

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int nstep   = 0;
    logic [23:0] exp_q [$];

    int cnt16 [4][16];
    int cnt1k [10][1024];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output bundle c cycles after start (c=0 is the start cycle).
    function automatic logic [23:0] exp_vec(input int c);
        logic       be, de, re, we;
        logic [2:0] ra, rb, rs, wa, wb, ws;
        logic [1:0] tw;
        int s, off, cw;
        be = (c >= 1) && (c <= TLP);
        de = (c == TLP + 1);
        {re, ra, rb, rs, tw, we, wa, wb, ws} = '0;
        if (c >= 1 && c <= TLP) begin
            s = (c - 1) / TP;
            off = (c - 1) % TP;
            if (off < 4) begin
                re = 1'b1;
                ra = 3'(ta[s*4+off]);
                rb = 3'(tb_[s*4+off]);
                tw = 2'(ttw[s*4+off]);
                rs = 3'(s);
            end
        end
        cw = c - 2;
        if (cw >= 1 && cw <= TLP) begin
            s = (cw - 1) / TP;
            off = (cw - 1) % TP;
            if (off < 4) begin
                we = 1'b1;
                wa = 3'(ta[s*4+off]);
                wb = 3'(tb_[s*4+off]);
                ws = 3'(s);
            end
        end
        return {be, de, re, ra, rb, tw, rs, we, wa, wb, ws};
    endfunction

    // One cycle: drive inputs, push trace on an accepted start, compare at negedge.
    task automatic step(input logic st, input logic ab, input string tag);
        logic [23:0] e;
        start = st;
        abort = ab;
        if (st && !ab && exp_q.size() == 0)
            for (int c = 0; c <= TLP + 1; c++) exp_q.push_back(exp_vec(c));
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'h0;
        nstep++;
        chk($sformatf("%s step%0d", tag, nstep), 64'(obs8), 64'(e));
        if (ab) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_at, ndone, nwr, bad, ok;

        // Reset held, then idle with no start
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset", 64'(obs8), 64'h0);
        rst_n = 1'b1;
        repeat (20) step(1'b0, 1'b0, "idle");

        // Full run
        step(1'b1, 1'b0, "full");
        repeat (TLP + 2) step(1'b0, 1'b0, "full");

        // Start pulses while busy and in DONE are ignored; restart right after DONE
        step(1'b1, 1'b0, "busy_start");
        for (int c = 1; c <= TLP; c++) step((c == 3) || (c == 10), 1'b0, "busy_start");
        step(1'b1, 1'b0, "done_start");
        step(1'b1, 1'b0, "b2b");
        repeat (TLP + 2) step(1'b0, 1'b0, "b2b");

        // Abort in stage 1, then fresh start
        step(1'b1, 1'b0, "abort");
        repeat (7) step(1'b0, 1'b0, "abort");
        step(1'b0, 1'b1, "abort");
        repeat (3) step(1'b0, 1'b0, "post_abort");
        step(1'b1, 1'b0, "restart");
        repeat (TLP + 2) step(1'b0, 1'b0, "restart");

        // Asynchronous reset between edges
        step(1'b1, 1'b0, "arst");
        repeat (13) step(1'b0, 1'b0, "arst");
        chk("arst_pre", 64'(obs8), 64'(exp_q.pop_front()));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_now", 64'(obs8), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        repeat (2) step(1'b0, 1'b0, "arst_hold");
        rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b0, "arst_idle");

        // Sweep N=16, BF_LAT=1
        done_at = -1; ndone = 0; nwr = 0; bad = 0;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (rd_en16) begin
                if (int'(rds16) < 4) begin
                    cnt16[int'(rds16)][int'(rda16)]++;
                    cnt16[int'(rds16)][int'(rdb16)]++;
                end else bad++;
            end
            if (wr_en16) nwr++;
            if (done16) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            @(posedge clk);
            #1;
        end
        for (int s = 0; s < 4; s++) begin
            ok = 1;
            for (int a = 0; a < 16; a++) if (cnt16[s][a] != 1) ok = 0;
            chk($sformatf("n16_cover_stage%0d", s), 64'(ok), 64'd1);
        end
        chk("n16_bad_stage", 64'(bad), 64'd0);
        chk("n16_done_cycle", 64'(done_at), 64'd37);
        chk("n16_done_count", 64'(ndone), 64'd1);
        chk("n16_writes", 64'(nwr), 64'd32);

        // Sweep N=1024, BF_LAT=8
        done_at = -1; ndone = 0; nwr = 0; bad = 0;
        start1k = 1'b1;
        @(posedge clk);
        #1;
        start1k = 1'b0;
        for (int c = 1; c <= 5210; c++) begin
            @(negedge clk);
            if (rd_en1k) begin
                if (int'(rds1k) < 10) begin
                    cnt1k[int'(rds1k)][int'(rda1k)]++;
                    cnt1k[int'(rds1k)][int'(rdb1k)]++;
                end else bad++;
            end
            if (wr_en1k) nwr++;
            if (done1k) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            @(posedge clk);
            #1;
        end
        for (int s = 0; s < 10; s++) begin
            ok = 1;
            for (int a = 0; a < 1024; a++) if (cnt1k[s][a] != 1) ok = 0;
            chk($sformatf("n1k_cover_stage%0d", s), 64'(ok), 64'd1);
        end
        chk("n1k_bad_stage", 64'(bad), 64'd0);
        chk("n1k_done_cycle", 64'(done_at), 64'd5201);
        chk("n1k_done_count", 64'(ndone), 64'd1);
        chk("n1k_writes", 64'(nwr), 64'd5120);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
